// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-master arbiter in front of a single-port data memory.
//
// m0 (core) normally has priority over m1 (DMA). m1 may lock the memory for a
// burst of up to MAX_BURST consecutive beats. When DMEM_ARB_STARVE_GUARD_EN is
// defined, m1 is forced a slot after STARVE_LIMIT consecutive waiting cycles;
// without it m0 strictly wins except during a locked m1 burst.
//
// Ports:
//   clk, resetn                        clock, asynchronous active-low reset
//   m0_req/we/addr/wdata/sel           core request (held stable until granted)
//   m0_gnt, m0_rvalid, m0_rdata        core grant, read-valid pulse, read data
//   m1_req/we/lock/addr/wdata/sel      DMA request; m1_lock asks for a burst
//   m1_gnt, m1_rvalid, m1_rdata        DMA grant, read-valid pulse, read data
//   mem_we/addr/wdata/sel, mem_rdata   memory side (mem_rdata combinational)
module dmem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned MAX_BURST    = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_sel,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic        m1_lock,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_sel,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_sel,
  input  logic [31:0] mem_rdata
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
    $error("STARVE_LIMIT must be in 1..15");
  end
  if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_max_burst
    $error("MAX_BURST must be in 1..15");
  end

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} owner_e;

  localparam logic [3:0] BurstLast = 4'(MAX_BURST - 1);

  owner_e      owner_q, owner_d;
  logic [3:0]  burst_cnt_q, burst_cnt_d;
  logic        m0_rvalid_q, m1_rvalid_q;
  logic [31:0] m0_rdata_q, m1_rdata_q;
  logic        m0_acc, m1_acc;
  logic        burst_hold;
  logic        starve_force;

  // Grants come straight from the owner register, never from the requests.
  assign m0_gnt = (owner_q == StOwn0);
  assign m1_gnt = (owner_q == StOwn1);
  assign m0_acc = m0_gnt && m0_req;
  assign m1_acc = m1_gnt && m1_req;

`ifdef DMEM_ARB_STARVE_GUARD_EN
  localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt_q, starve_cnt_d;

  always_comb begin
    starve_cnt_d = '0;
    if (m1_req && !m1_acc) begin
      starve_cnt_d = (starve_cnt_q == StarveMax) ? starve_cnt_q : starve_cnt_q + 4'd1;
    end
  end

  // The count includes the cycle currently being waited, so m1 is handed the
  // memory right after its STARVE_LIMIT-th waiting cycle.
  assign starve_force = m1_req && (starve_cnt_d == StarveMax);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  assign starve_force = 1'b0;
`endif

  assign burst_hold = (owner_q == StOwn1) && m1_lock && m1_req && (burst_cnt_q < BurstLast);

  always_comb begin
    owner_d = StIdle;
    if (burst_hold) begin
      owner_d = StOwn1;
    end else if (starve_force) begin
      owner_d = StOwn1;
    end else if (m0_req) begin
      owner_d = StOwn0;
    end else if (m1_req) begin
      owner_d = StOwn1;
    end
  end

  // A burst that reaches MAX_BURST beats restarts from zero so that m1, if it
  // keeps the memory through normal arbitration, begins a fresh burst.
  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if (owner_d != StOwn1 || !m1_lock) begin
      burst_cnt_d = '0;
    end else if (m1_acc) begin
      burst_cnt_d = (burst_cnt_q == BurstLast) ? 4'd0 : burst_cnt_q + 4'd1;
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_sel   = '0;
    if (m0_acc) begin
      mem_we    = m0_we;
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
      mem_sel   = m0_sel;
    end else if (m1_acc) begin
      mem_we    = m1_we;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
      mem_sel   = m1_sel;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      owner_q     <= StIdle;
      burst_cnt_q <= '0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      m0_rvalid_q <= m0_acc && !m0_we;
      m1_rvalid_q <= m1_acc && !m1_we;
      if (m0_acc && !m0_we) begin
        m0_rdata_q <= mem_rdata;
      end
      if (m1_acc && !m1_we) begin
        m1_rdata_q <= mem_rdata;
      end
    end
  end

  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: table-driven bench for dmem_arbiter with an rdata scoreboard.
// Expectations follow DMEM_ARB_STARVE_GUARD_EN the same way the design does.
module tb_dmem_arbiter;

  localparam int unsigned StarveLimit = 4;
  localparam int unsigned MaxBurst    = 8;

  logic        clk;
  logic        resetn;
  logic        m0_req, m0_we;
  logic [31:0] m0_addr, m0_wdata;
  logic [3:0]  m0_sel;
  logic        m0_gnt, m0_rvalid;
  logic [31:0] m0_rdata;
  logic        m1_req, m1_we, m1_lock;
  logic [31:0] m1_addr, m1_wdata;
  logic [3:0]  m1_sel;
  logic        m1_gnt, m1_rvalid;
  logic [31:0] m1_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_sel;

  dmem_arbiter #(
    .STARVE_LIMIT(StarveLimit),
    .MAX_BURST   (MaxBurst)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .m0_req   (m0_req),
    .m0_we    (m0_we),
    .m0_addr  (m0_addr),
    .m0_wdata (m0_wdata),
    .m0_sel   (m0_sel),
    .m0_gnt   (m0_gnt),
    .m0_rvalid(m0_rvalid),
    .m0_rdata (m0_rdata),
    .m1_req   (m1_req),
    .m1_we    (m1_we),
    .m1_lock  (m1_lock),
    .m1_addr  (m1_addr),
    .m1_wdata (m1_wdata),
    .m1_sel   (m1_sel),
    .m1_gnt   (m1_gnt),
    .m1_rvalid(m1_rvalid),
    .m1_rdata (m1_rdata),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_sel  (mem_sel),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          grp;
    int          cyc;
    logic        m0_req;
    logic        m0_we;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic [3:0]  m0_sel;
    logic        m1_req;
    logic        m1_we;
    logic        m1_lock;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic [3:0]  m1_sel;
    logic [31:0] rdata;
    logic        exp_g0;
    logic        exp_g1;
  } vec_t;

  vec_t        vecs[$];
  int          n_vec;
  int          n_err;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic        pend_rv0, pend_rv1;
  logic [31:0] hold_rd0, hold_rd1;

  task automatic check(input string what, input int grp, input int cyc,
                       input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s g%0d c%0d: got 0x%08h, want 0x%08h", what, grp, cyc, act, exp);
    end
  endtask

  function automatic vec_t idle_vec(input int grp, input int cyc);
    vec_t v;
    v.grp      = grp;
    v.cyc      = cyc;
    v.m0_req   = 1'b0;
    v.m0_we    = 1'b0;
    v.m0_addr  = '0;
    v.m0_wdata = '0;
    v.m0_sel   = '0;
    v.m1_req   = 1'b0;
    v.m1_we    = 1'b0;
    v.m1_lock  = 1'b0;
    v.m1_addr  = '0;
    v.m1_wdata = '0;
    v.m1_sel   = '0;
    v.rdata    = '0;
    v.exp_g0   = 1'b0;
    v.exp_g1   = 1'b0;
    return v;
  endfunction

  task automatic drive_idle();
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0; m0_sel = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_lock = 1'b0; m1_addr = '0; m1_wdata = '0; m1_sel = '0;
    mem_rdata = '0;
  endtask

  task automatic clear_model();
    q0.delete();
    q1.delete();
    pend_rv0 = 1'b0;
    pend_rv1 = 1'b0;
    hold_rd0 = '0;
    hold_rd1 = '0;
  endtask

  // Read-valid and read-data scoreboard for one cycle, both masters.
  task automatic score_reads(input int grp, input int cyc);
    check("m0_rvalid", grp, cyc, 32'(m0_rvalid), 32'(pend_rv0));
    if (m0_rvalid === 1'b1) begin
      if (q0.size() == 0) begin
        n_err++;
        $display("FAIL m0_rvalid_spurious g%0d c%0d: got 1, want 0", grp, cyc);
      end else begin
        hold_rd0 = q0.pop_front();
      end
    end
    check("m0_rdata", grp, cyc, m0_rdata, hold_rd0);
    check("m1_rvalid", grp, cyc, 32'(m1_rvalid), 32'(pend_rv1));
    if (m1_rvalid === 1'b1) begin
      if (q1.size() == 0) begin
        n_err++;
        $display("FAIL m1_rvalid_spurious g%0d c%0d: got 1, want 0", grp, cyc);
      end else begin
        hold_rd1 = q1.pop_front();
      end
    end
    check("m1_rdata", grp, cyc, m1_rdata, hold_rd1);
  endtask

  task automatic apply(input vec_t v);
    logic        acc0, acc1;
    logic        e_we;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_sel;
    m0_req = v.m0_req; m0_we = v.m0_we; m0_addr = v.m0_addr;
    m0_wdata = v.m0_wdata; m0_sel = v.m0_sel;
    m1_req = v.m1_req; m1_we = v.m1_we; m1_lock = v.m1_lock; m1_addr = v.m1_addr;
    m1_wdata = v.m1_wdata; m1_sel = v.m1_sel;
    mem_rdata = v.rdata;
    @(negedge clk);
    n_vec++;
    check("m0_gnt", v.grp, v.cyc, 32'(m0_gnt), 32'(v.exp_g0));
    check("m1_gnt", v.grp, v.cyc, 32'(m1_gnt), 32'(v.exp_g1));
    acc0 = v.exp_g0 && v.m0_req;
    acc1 = v.exp_g1 && v.m1_req;
    e_we = 1'b0; e_addr = '0; e_wdata = '0; e_sel = '0;
    if (acc0) begin
      e_we = v.m0_we; e_addr = v.m0_addr; e_wdata = v.m0_wdata; e_sel = v.m0_sel;
    end else if (acc1) begin
      e_we = v.m1_we; e_addr = v.m1_addr; e_wdata = v.m1_wdata; e_sel = v.m1_sel;
    end
    check("mem_we", v.grp, v.cyc, 32'(mem_we), 32'(e_we));
    check("mem_addr", v.grp, v.cyc, mem_addr, e_addr);
    check("mem_wdata", v.grp, v.cyc, mem_wdata, e_wdata);
    check("mem_sel", v.grp, v.cyc, 32'(mem_sel), 32'(e_sel));
    score_reads(v.grp, v.cyc);
    pend_rv0 = acc0 && !v.m0_we;
    pend_rv1 = acc1 && !v.m1_we;
    if (pend_rv0) q0.push_back(v.rdata);
    if (pend_rv1) q1.push_back(v.rdata);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    int   b;
    n_vec  = 0;
    n_err  = 0;
    resetn = 1'b0;
    drive_idle();
    clear_model();

    // Group 1: m0 reads 0x10 for three cycles.
    v = idle_vec(1, 1); v.m0_req = 1'b1; v.m0_addr = 32'h10; v.m0_sel = 4'hF;
    v.rdata = 32'hDEAD_BEEF; vecs.push_back(v);
    v.cyc = 2; v.exp_g0 = 1'b1; vecs.push_back(v);
    v.cyc = 3; vecs.push_back(v);
    v = idle_vec(1, 4); v.exp_g0 = 1'b1; vecs.push_back(v);
    v = idle_vec(1, 5); vecs.push_back(v);

    // Group 2: single m1 write, then request dropped while still owner.
    v = idle_vec(2, 1); v.m1_req = 1'b1; v.m1_we = 1'b1; v.m1_addr = 32'h40;
    v.m1_wdata = 32'h1234_5678; v.m1_sel = 4'b0011; vecs.push_back(v);
    v.cyc = 2; v.exp_g1 = 1'b1; vecs.push_back(v);
    v = idle_vec(2, 3); v.exp_g1 = 1'b1; vecs.push_back(v);
    v = idle_vec(2, 4); vecs.push_back(v);

    // Group 3: m0 write and m1 read collide; m0 first, m1 after.
    v = idle_vec(3, 1); v.m0_req = 1'b1; v.m0_we = 1'b1; v.m0_addr = 32'h20;
    v.m0_wdata = 32'hA5A5_A5A5; v.m0_sel = 4'hF; v.m1_req = 1'b1; v.m1_addr = 32'h80;
    v.m1_sel = 4'hF; v.rdata = 32'hCAFE_F00D; vecs.push_back(v);
    v.cyc = 2; v.exp_g0 = 1'b1; vecs.push_back(v);
    v.cyc = 3; v.m0_req = 1'b0; v.m0_we = 1'b0; v.m0_addr = '0; v.m0_wdata = '0;
    v.m0_sel = '0; vecs.push_back(v);
    v.cyc = 4; v.exp_g0 = 1'b0; v.exp_g1 = 1'b1; vecs.push_back(v);
    v = idle_vec(3, 5); v.exp_g1 = 1'b1; vecs.push_back(v);
    v = idle_vec(3, 6); vecs.push_back(v);

    // Group 4: both masters read continuously.
    for (int i = 0; i < 15; i++) begin
      v = idle_vec(4, i + 1);
      v.m0_req = 1'b1; v.m0_addr = 32'h100; v.m0_sel = 4'hF;
      v.m1_req = 1'b1; v.m1_addr = 32'h200; v.m1_sel = 4'hF;
      v.rdata = 32'h1000_0000 + 32'(i);
`ifdef DMEM_ARB_STARVE_GUARD_EN
      v.exp_g1 = ((i % 5) == 4);
`else
      v.exp_g1 = 1'b0;
`endif
      v.exp_g0 = (i != 0) && !v.exp_g1;
      vecs.push_back(v);
    end
    v = idle_vec(4, 16); v.exp_g0 = 1'b1; vecs.push_back(v);
    v = idle_vec(4, 17); vecs.push_back(v);

    // Group 5: 10-beat locked m1 write burst against a waiting m0 read.
    b = 1;
    for (int j = 1; j <= 15; j++) begin
      v = idle_vec(5, j);
      if (j <= 13) begin
        v.m1_req = 1'b1; v.m1_we = 1'b1; v.m1_lock = 1'b1; v.m1_sel = 4'hF;
        v.m1_addr = 32'h300 + 32'(4 * b); v.m1_wdata = 32'hB000_0000 + 32'(b);
      end
      if (j >= 2 && j <= 10) begin
        v.m0_req = 1'b1; v.m0_addr = 32'h50; v.m0_sel = 4'hF;
      end
      v.rdata  = 32'h5555_AAAA;
      v.exp_g1 = (j >= 2 && j <= 9) || (j >= 12 && j <= 14);
      v.exp_g0 = (j == 10) || (j == 11);
      vecs.push_back(v);
      if (v.exp_g1 && v.m1_req) b++;
    end

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_m0_gnt", 0, 0, 32'(m0_gnt), 32'd0);
    check("rst_m1_gnt", 0, 0, 32'(m1_gnt), 32'd0);
    check("rst_m0_rvalid", 0, 0, 32'(m0_rvalid), 32'd0);
    check("rst_m1_rvalid", 0, 0, 32'(m1_rvalid), 32'd0);
    check("rst_m0_rdata", 0, 0, m0_rdata, 32'd0);
    check("rst_m1_rdata", 0, 0, m1_rdata, 32'd0);
    check("rst_mem_we", 0, 0, 32'(mem_we), 32'd0);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[k]) apply(vecs[k]);
    check("q0_drained", 5, 99, 32'(q0.size()), 32'd0);
    check("q1_drained", 5, 99, 32'(q1.size()), 32'd0);

    // Group 6: reset asserted in the middle of an m0 write access.
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h60; m0_wdata = 32'h0BAD_F00D; m0_sel = 4'hF;
    @(negedge clk);
    check("g6_gnt_c1", 6, 1, 32'(m0_gnt), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("g6_gnt_c2", 6, 2, 32'(m0_gnt), 32'd1);
    check("g6_we_c2", 6, 2, 32'(mem_we), 32'd1);
    check("g6_addr_c2", 6, 2, mem_addr, 32'h60);
    #2;
    resetn = 1'b0;
    #1;
    check("g6_rst_we", 6, 2, 32'(mem_we), 32'd0);
    check("g6_rst_gnt", 6, 2, 32'(m0_gnt), 32'd0);
    check("g6_rst_addr", 6, 2, mem_addr, 32'd0);
    @(posedge clk);
    #1;
    check("g6_rst_hold_we", 6, 3, 32'(mem_we), 32'd0);
    check("g6_rst_hold_gnt", 6, 3, 32'(m0_gnt), 32'd0);
    check("g6_rst_m0_rdata", 6, 3, m0_rdata, 32'd0);
    check("g6_rst_m1_rdata", 6, 3, m1_rdata, 32'd0);
    drive_idle();
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("g6_post_m0_rvalid", 6, 4 + i, 32'(m0_rvalid), 32'd0);
      check("g6_post_m1_rvalid", 6, 4 + i, 32'(m1_rvalid), 32'd0);
      check("g6_post_gnt", 6, 4 + i, 32'(m0_gnt), 32'd0);
      check("g6_post_we", 6, 4 + i, 32'(mem_we), 32'd0);
    end

    // Group 7: arbitration resumes normally after the reset.
    clear_model();
    vecs.delete();
    v = idle_vec(7, 1); v.m1_req = 1'b1; v.m1_addr = 32'h44; v.m1_sel = 4'hF;
    v.rdata = 32'h0000_0077; vecs.push_back(v);
    v.cyc = 2; v.exp_g1 = 1'b1; vecs.push_back(v);
    v = idle_vec(7, 3); v.exp_g1 = 1'b1; vecs.push_back(v);
    v = idle_vec(7, 4); vecs.push_back(v);
    foreach (vecs[k]) apply(vecs[k]);
    check("q1_drained_g7", 7, 99, 32'(q1.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
